// File: rtl/ex_operand_stage_pkg.sv
// Shared constants and types for the ID/EX operand stage and its forwarding helpers.
package ex_operand_stage_pkg;

  localparam int unsigned SIZE_DEFAULT    = 32;
  localparam int unsigned REGADDR_DEFAULT = 5;
  localparam int unsigned ZERO_REG        = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stageStateT;

endpackage

// File: rtl/ex_operand_stage_forward_select.sv
// Combinational operand forwarding: x0, then EX/MEM (non-load), then MEM/WB, then register file.
module forward_select
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned SIZE    = SIZE_DEFAULT,
  parameter int unsigned REGADDR = REGADDR_DEFAULT
) (
  input  logic [REGADDR-1:0] addr,
  input  logic [SIZE-1:0]    rfData,
  input  logic               memValid,
  input  logic               memIsLoad,
  input  logic [REGADDR-1:0] memRd,
  input  logic [SIZE-1:0]    memData,
  input  logic               wbValid,
  input  logic [REGADDR-1:0] wbRd,
  input  logic [SIZE-1:0]    wbData,
  output logic [SIZE-1:0]    fwdData
);

  // The younger EX/MEM result wins over MEM/WB; a load in EX/MEM has no data yet.
  always_comb begin
    fwdData = rfData;
    if (addr == REGADDR'(ZERO_REG)) begin
      fwdData = '0;
    end else if (memValid && !memIsLoad && (memRd == addr)) begin
      fwdData = memData;
    end else if (wbValid && (wbRd == addr)) begin
      fwdData = wbData;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the arithmeticUnit: handshake, operand forwarding,
// immediate selection and load-use hazard stall.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned SIZE    = SIZE_DEFAULT,
  parameter int unsigned REGADDR = REGADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inValid,
  output logic               inReady,
  input  logic [REGADDR-1:0] rs1Addr,
  input  logic [REGADDR-1:0] rs2Addr,
  input  logic [SIZE-1:0]    rs1Data,
  input  logic [SIZE-1:0]    rs2Data,
  input  logic [SIZE-1:0]    immediate,
  input  logic               useImm,
  input  logic               isSub,
  input  logic [REGADDR-1:0] rdAddrIn,
  input  logic               regWriteIn,
  input  logic               memFwdValid,
  input  logic [REGADDR-1:0] memFwdRd,
  input  logic [SIZE-1:0]    memFwdData,
  input  logic               memFwdIsLoad,
  input  logic               wbFwdValid,
  input  logic [REGADDR-1:0] wbFwdRd,
  input  logic [SIZE-1:0]    wbFwdData,
  input  logic               flush,
  output logic               outValid,
  input  logic               outReady,
  output logic [SIZE-1:0]    operandA,
  output logic [SIZE-1:0]    operandB,
  output logic               control,
  output logic [REGADDR-1:0] rdAddrOut,
  output logic               regWriteOut
);

  stageStateT state;
  stageStateT nextState;

  logic            hazard;
  logic            capture;
  logic [SIZE-1:0] fwdA;
  logic [SIZE-1:0] fwdB;
  logic [SIZE-1:0] selB;

  forward_select #(.SIZE(SIZE), .REGADDR(REGADDR)) fwdSelA (
    .addr      (rs1Addr),
    .rfData    (rs1Data),
    .memValid  (memFwdValid),
    .memIsLoad (memFwdIsLoad),
    .memRd     (memFwdRd),
    .memData   (memFwdData),
    .wbValid   (wbFwdValid),
    .wbRd      (wbFwdRd),
    .wbData    (wbFwdData),
    .fwdData   (fwdA)
  );

  forward_select #(.SIZE(SIZE), .REGADDR(REGADDR)) fwdSelB (
    .addr      (rs2Addr),
    .rfData    (rs2Data),
    .memValid  (memFwdValid),
    .memIsLoad (memFwdIsLoad),
    .memRd     (memFwdRd),
    .memData   (memFwdData),
    .wbValid   (wbFwdValid),
    .wbRd      (wbFwdRd),
    .wbData    (wbFwdData),
    .fwdData   (fwdB)
  );

  // rs2 is not a real source when the immediate replaces operand B.
  always_comb begin
    hazard = 1'b0;
    if (memFwdValid && memFwdIsLoad && (memFwdRd != REGADDR'(ZERO_REG))) begin
      hazard = (memFwdRd == rs1Addr) || (!useImm && (memFwdRd == rs2Addr));
    end
  end

  assign outValid = (state == FULL);
  assign inReady  = (!outValid || outReady) && !hazard;
  assign capture  = inValid && inReady;
  assign selB     = useImm ? immediate : fwdB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Flush beats capture; a drain without a new capture empties the stage.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = EMPTY;
    end else if (capture) begin
      nextState = FULL;
    end else if (outReady) begin
      nextState = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operandA    <= '0;
      operandB    <= '0;
      control     <= 1'b0;
      rdAddrOut   <= '0;
      regWriteOut <= 1'b0;
    end else if (capture) begin
      operandA    <= fwdA;
      operandB    <= selB;
      control     <= isSub && !useImm;
      rdAddrOut   <= rdAddrIn;
      regWriteOut <= regWriteIn;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [4:0]  rs1Addr, rs2Addr, rdAddrIn, memFwdRd, wbFwdRd, rdAddrOut;
  logic [31:0] rs1Data, rs2Data, immediate, memFwdData, wbFwdData, operandA, operandB;
  logic        useImm, isSub, regWriteIn, memFwdValid, memFwdIsLoad, wbFwdValid, flush;
  logic        outValid, outReady, control, regWriteOut;

  int checks = 0;
  int errors = 0;

  // Reference state: one slot holding the instruction as the consumer must see it.
  logic        mValid;
  logic [31:0] mA, mB;
  logic        mCtl, mWe;
  logic [4:0]  mRd;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .immediate(immediate), .useImm(useImm), .isSub(isSub),
    .rdAddrIn(rdAddrIn), .regWriteIn(regWriteIn),
    .memFwdValid(memFwdValid), .memFwdRd(memFwdRd), .memFwdData(memFwdData),
    .memFwdIsLoad(memFwdIsLoad), .wbFwdValid(wbFwdValid), .wbFwdRd(wbFwdRd),
    .wbFwdData(wbFwdData), .flush(flush), .outValid(outValid), .outReady(outReady),
    .operandA(operandA), .operandB(operandB), .control(control),
    .rdAddrOut(rdAddrOut), .regWriteOut(regWriteOut)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelFwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (memFwdValid && !memFwdIsLoad && memFwdRd == a) return memFwdData;
    if (wbFwdValid && wbFwdRd == a) return wbFwdData;
    return rf;
  endfunction

  function automatic logic modelHazard();
    if (!(memFwdValid && memFwdIsLoad) || memFwdRd == 5'd0) return 1'b0;
    return (memFwdRd == rs1Addr) || (!useImm && memFwdRd == rs2Addr);
  endfunction

  task automatic modelReset();
    mValid = 1'b0; mA = '0; mB = '0; mCtl = 1'b0; mWe = 1'b0; mRd = '0;
  endtask

  task automatic clearInputs();
    inValid = 0; rs1Addr = 0; rs2Addr = 0; rs1Data = 0; rs2Data = 0; immediate = 0;
    useImm = 0; isSub = 0; rdAddrIn = 0; regWriteIn = 0; memFwdValid = 0; memFwdRd = 0;
    memFwdData = 0; memFwdIsLoad = 0; wbFwdValid = 0; wbFwdRd = 0; wbFwdData = 0;
    flush = 0; outReady = 1;
  endtask

  task automatic compareAll();
    chk("outValid", 32'(outValid), 32'(mValid));
    if (mValid) begin
      chk("operandA", operandA, mA);
      chk("operandB", operandB, mB);
      chk("control", 32'(control), 32'(mCtl));
      chk("rdAddrOut", 32'(rdAddrOut), 32'(mRd));
      chk("regWriteOut", 32'(regWriteOut), 32'(mWe));
    end
  endtask

  // One clock with the current inputs: check inReady, advance model, compare outputs.
  task automatic cycle();
    logic        rdy, cap, nValid, nCtl, nWe;
    logic [31:0] nA, nB;
    logic [4:0]  nRd;
    #1;
    rdy = (!mValid || outReady) && !modelHazard();
    chk("inReady", 32'(inReady), 32'(rdy));
    cap = inValid && rdy;
    nValid = flush ? 1'b0 : cap ? 1'b1 : outReady ? 1'b0 : mValid;
    nA = mA; nB = mB; nCtl = mCtl; nWe = mWe; nRd = mRd;
    if (cap) begin
      nA   = modelFwd(rs1Addr, rs1Data);
      nB   = useImm ? immediate : modelFwd(rs2Addr, rs2Data);
      nCtl = isSub && !useImm;
      nRd  = rdAddrIn;
      nWe  = regWriteIn;
    end
    @(posedge clk);
    #1;
    mValid = nValid; mA = nA; mB = nB; mCtl = nCtl; mWe = nWe; mRd = nRd;
    compareAll();
  endtask

  initial begin
    clearInputs();
    modelReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst outValid", 32'(outValid), 32'd0);
    chk("rst operandA", operandA, 32'd0);
    reset = 1'b0;

    // Plain subtract, no forwarding.
    inValid = 1; rs1Addr = 1; rs2Addr = 2; rs1Data = 5; rs2Data = 3; isSub = 1;
    rdAddrIn = 9; regWriteIn = 1;
    cycle();
    chk("t2 operandA", operandA, 32'd5);
    chk("t2 operandB", operandB, 32'd3);
    chk("t2 control", 32'(control), 32'd1);
    chk("t2 outValid", 32'(outValid), 32'd1);

    // Async reset while FULL clears everything before the next edge.
    reset = 1'b1;
    #1;
    chk("t1 async outValid", 32'(outValid), 32'd0);
    chk("t1 async operandA", operandA, 32'd0);
    chk("t1 async operandB", operandB, 32'd0);
    chk("t1 async control", 32'(control), 32'd0);
    chk("t1 async rdAddrOut", 32'(rdAddrOut), 32'd0);
    chk("t1 async regWriteOut", 32'(regWriteOut), 32'd0);
    modelReset();
    #3;
    reset = 1'b0;

    // MEM beats WB; rs2 = x0 never forwarded.
    clearInputs();
    inValid = 1; rs1Addr = 4; rs2Addr = 0; rs1Data = 32'h55; rs2Data = 32'h66;
    memFwdValid = 1; memFwdRd = 4; memFwdData = 32'h10;
    wbFwdValid = 1; wbFwdRd = 4; wbFwdData = 32'h20; isSub = 1;
    cycle();
    chk("t3 operandA", operandA, 32'h10);
    chk("t3 operandB", operandB, 32'h0);
    useImm = 1; immediate = 32'hFFFF_FFFC; rs2Addr = 4;
    cycle();
    chk("t3 imm operandB", operandB, 32'hFFFF_FFFC);
    chk("t3 imm control", 32'(control), 32'd0);

    // Load-use on rs2: stall with bubble, then capture with WB-forwarded data.
    clearInputs();
    inValid = 1; rs1Addr = 1; rs2Addr = 7; rs1Data = 1; rs2Data = 2;
    memFwdValid = 1; memFwdIsLoad = 1; memFwdRd = 7; memFwdData = 32'hDEAD;
    #1;
    chk("t4 hazard inReady", 32'(inReady), 32'd0);
    cycle();
    chk("t4 bubble outValid", 32'(outValid), 32'd0);
    memFwdValid = 0; memFwdIsLoad = 0; wbFwdValid = 1; wbFwdRd = 7; wbFwdData = 32'h99;
    cycle();
    chk("t4 operandB", operandB, 32'h99);
    chk("t4 outValid", 32'(outValid), 32'd1);

    // Backpressure holds outputs; release reloads back-to-back.
    clearInputs();
    inValid = 1; rs1Addr = 3; rs2Addr = 5; rs1Data = 32'h111; rs2Data = 32'h222;
    cycle();
    outReady = 0;
    for (int i = 0; i < 3; i++) begin
      rs1Data = $urandom; rs2Data = $urandom; rdAddrIn = 5'($urandom);
      #1;
      chk("t5 hold inReady", 32'(inReady), 32'd0);
      cycle();
      chk("t5 hold operandA", operandA, 32'h111);
      chk("t5 hold operandB", operandB, 32'h222);
    end
    outReady = 1; rs1Data = 32'h333;
    cycle();
    chk("t5 b2b outValid", 32'(outValid), 32'd1);
    chk("t5 b2b operandA", operandA, 32'h333);

    // Flush discards a concurrent capture.
    clearInputs();
    inValid = 1; flush = 1; rs1Addr = 2; rs1Data = 32'h777;
    cycle();
    chk("t6 flush outValid", 32'(outValid), 32'd0);
    flush = 0; rs1Data = 32'hABC;
    cycle();
    chk("t6 after outValid", 32'(outValid), 32'd1);
    chk("t6 after operandA", operandA, 32'hABC);

    // Randomized traffic with small register indices to provoke matches.
    for (int n = 0; n < 2000; n++) begin
      inValid      = ($urandom_range(0, 3) != 0);
      rs1Addr      = 5'($urandom_range(0, 7));
      rs2Addr      = 5'($urandom_range(0, 7));
      rs1Data      = $urandom;
      rs2Data      = $urandom;
      immediate    = $urandom;
      useImm       = 1'($urandom_range(0, 1));
      isSub        = 1'($urandom_range(0, 1));
      rdAddrIn     = 5'($urandom);
      regWriteIn   = 1'($urandom_range(0, 1));
      memFwdValid  = 1'($urandom_range(0, 1));
      memFwdRd     = 5'($urandom_range(0, 7));
      memFwdData   = $urandom;
      memFwdIsLoad = ($urandom_range(0, 9) < 3);
      wbFwdValid   = 1'($urandom_range(0, 1));
      wbFwdRd      = 5'($urandom_range(0, 7));
      wbFwdData    = $urandom;
      flush        = ($urandom_range(0, 15) == 0);
      outReady     = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
